fifo_wr_arbiter: RTL and testbench

Write-side arbiter that shares the single write port of the asynchronous FIFO among `NREQ` packet-producing requesters in the write clock domain. It grants one requester at a time using round-robin priority and holds the grant until that requester's packet ends or a beat cap is hit. It drives the FIFO's `winc` and `wdata` and honours `wfull`, so no beat is ever lost or duplicated.

---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/fifo_wr_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
//   arb_state_t : arbiter FSM state (IDLE waiting to grant, LOCK serving a grant)
//   clog2_min1  : ceil(log2(n)) clamped to at least 1 bit, for index/counter widths
package fifo_arb_pkg;

    typedef enum logic {IDLE, LOCK} arb_state_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick among NREQ requests.
//   req_i     : request vector
//   last_id_i : previously granted index; search starts one above it
//   winner_o  : granted index (meaningless when any_o is low)
//   any_o     : at least one request is present
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_id_i,
    output logic [IDW-1:0]  winner_o,
    output logic            any_o
);

    logic [NREQ-1:0] rot;
    int unsigned     start;
    int unsigned     enc;
    logic            found;

    always_comb begin
        start = (32'(last_id_i) + 1) % NREQ;
        // Rotate so the highest-priority requester sits at bit 0.
        rot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rot[i] = req_i[(start + i) % NREQ];
        end
        // Lowest set bit of the rotated vector wins.
        found = 1'b0;
        enc   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                enc   = i;
            end
        end
        // Un-rotate back to a requester index.
        winner_o = IDW'((start + enc) % NREQ);
        any_o    = |req_i;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the single FIFO write port among NREQ packet producers. A round-robin
// grant is held until the packet's last beat or until MAXBEATS beats have gone.
//   wclk, wrst_n : write clock, async active-low reset
//   req_valid    : per-requester beat valid
//   req_last     : per-requester last-beat marker
//   req_data     : packed beats, requester i at [i*DSIZE +: DSIZE]
//   req_ready    : one-hot (or zero) accept to the granted requester
//   wfull        : FIFO full flag
//   winc, wdata  : FIFO write strobe and data
//   grant_id     : current or last granted requester (registered)
//   busy         : a grant is held (registered)
//   cap_err      : one-cycle pulse when a grant was cut at MAXBEATS without last
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned DSIZE    = 8,
    parameter int unsigned MAXBEATS = 16,
    parameter int unsigned IDW      = clog2_min1(NREQ)
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy,
    output logic                  cap_err
);

    localparam int unsigned CW = clog2_min1(MAXBEATS + 1);

    arb_state_t      state_q, state_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  last_id_q, last_id_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            cap_err_q, cap_err_d;

    logic [IDW-1:0]  winner;
    logic            any_req;
    logic            accept;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req_i     (req_valid),
        .last_id_i (last_id_q),
        .winner_o  (winner),
        .any_o     (any_req)
    );

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        beat_cnt_d = beat_cnt_q;
        cap_err_d  = 1'b0;
        req_ready  = '0;
        winc       = 1'b0;
        accept     = 1'b0;
        wdata      = req_data[32'(grant_id_q) * DSIZE +: DSIZE];

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_id_d = winner;
                    beat_cnt_d = '0;
                    state_d    = LOCK;
                end
            end
            LOCK: begin
                // wfull only gates the handshake; grant and count simply hold.
                accept                = req_valid[grant_id_q] & ~wfull;
                req_ready[grant_id_q] = ~wfull;
                winc                  = accept;
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (req_last[grant_id_q]) begin
                        state_d   = IDLE;
                        last_id_d = grant_id_q;
                    end else if (beat_cnt_q + CW'(1) == CW'(MAXBEATS)) begin
                        // Forced release; the rest of the packet re-arbitrates.
                        cap_err_d = 1'b1;
                        state_d   = IDLE;
                        last_id_d = grant_id_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            last_id_q  <= IDW'(NREQ - 1);
            beat_cnt_q <= '0;
            cap_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            beat_cnt_q <= beat_cnt_d;
            cap_err_q  <= cap_err_d;
        end
    end

    assign grant_id = grant_id_q;
    assign busy     = (state_q == LOCK);
    assign cap_err  = cap_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned DSIZE = 8;

    logic              wclk;
    logic              wrst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [NREQ*DSIZE-1:0] req_data;
    logic              wfull;
    logic [3:0]        dnib;

    // Instance a: MAXBEATS=16, instance b: MAXBEATS=4; both see the same stimulus.
    logic [NREQ-1:0]   ready_a, ready_b;
    logic              winc_a, winc_b;
    logic [DSIZE-1:0]  wdata_a, wdata_b;
    logic [1:0]        gid_a, gid_b;
    logic              busy_a, busy_b;
    logic              cap_a, cap_b;

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter #(
        .NREQ     (NREQ),
        .DSIZE    (DSIZE),
        .MAXBEATS (16)
    ) dut_a (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (ready_a),
        .wfull     (wfull),
        .winc      (winc_a),
        .wdata     (wdata_a),
        .grant_id  (gid_a),
        .busy      (busy_a),
        .cap_err   (cap_a)
    );

    fifo_wr_arbiter #(
        .NREQ     (NREQ),
        .DSIZE    (DSIZE),
        .MAXBEATS (4)
    ) dut_b (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (ready_b),
        .wfull     (wfull),
        .winc      (winc_b),
        .wdata     (wdata_b),
        .grant_id  (gid_b),
        .busy      (busy_b),
        .cap_err   (cap_b)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Requester i presents {i, dnib}, so wdata identifies both source and beat.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DSIZE +: DSIZE] = {4'(i), dnib};
        end
    end

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       f;
        logic [3:0] d;
        logic       e_winc;
        logic [3:0] e_ready;
        logic       e_busy;
        logic [1:0] e_gid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic f, logic [3:0] d,
                                logic ew, logic [3:0] er, logic eb, logic [1:0] eg);
        vec_t t;
        t.v = v; t.l = l; t.f = f; t.d = d;
        t.e_winc = ew; t.e_ready = er; t.e_busy = eb; t.e_gid = eg;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f,
                         input logic [3:0] d);
        req_valid = v;
        req_last  = l;
        wfull     = f;
        dnib      = d;
        @(negedge wclk);
    endtask

    task automatic adv();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic ew, input logic [3:0] er,
                         input logic eb, input logic [1:0] eg, input logic [3:0] d);
        check({tag, ".winc"}, 32'(winc_a), 32'(ew));
        check({tag, ".ready"}, 32'(ready_a), 32'(er));
        check({tag, ".busy"}, 32'(busy_a), 32'(eb));
        check({tag, ".gid"}, 32'(gid_a), 32'(eg));
        check({tag, ".cap"}, 32'(cap_a), 32'd0);
        if (ew) check({tag, ".wdata"}, 32'(wdata_a), {24'd0, 2'b00, eg, d});
    endtask

    task automatic chk_b(input string tag, input logic ew, input logic [3:0] er,
                         input logic ec, input logic eb, input logic [1:0] eg,
                         input logic [3:0] d);
        check({tag, ".winc"}, 32'(winc_b), 32'(ew));
        check({tag, ".ready"}, 32'(ready_b), 32'(er));
        check({tag, ".cap"}, 32'(cap_b), 32'(ec));
        check({tag, ".busy"}, 32'(busy_b), 32'(eb));
        check({tag, ".gid"}, 32'(gid_b), 32'(eg));
        if (ew) check({tag, ".wdata"}, 32'(wdata_b), {24'd0, 2'b00, eg, d});
    endtask

    task automatic do_reset();
        wrst_n    = 1'b0;
        req_valid = '0;
        req_last  = '0;
        wfull     = 1'b0;
        dnib      = '0;
        #1;
        check("rst.winc_a", 32'(winc_a), 0);
        check("rst.ready_a", 32'(ready_a), 0);
        check("rst.busy_a", 32'(busy_a), 0);
        check("rst.gid_a", 32'(gid_a), 0);
        check("rst.cap_b", 32'(cap_b), 0);
        check("rst.busy_b", 32'(busy_b), 0);
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        adv();
    endtask

    initial begin
        // Reset priority: 1-beat packets from all four, grants 0,1,2,3,0 with bubbles.
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'd0, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'd1, 1, 4'b0001, 1, 2'd0));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'd0, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'd2, 1, 4'b0010, 1, 2'd1));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'd0, 0, 4'b0000, 0, 2'd1));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'd3, 1, 4'b0100, 1, 2'd2));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'd0, 0, 4'b0000, 0, 2'd2));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'd4, 1, 4'b1000, 1, 2'd3));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'd0, 0, 4'b0000, 0, 2'd3));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'd5, 1, 4'b0001, 1, 2'd0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'd0, 0, 4'b0000, 0, 2'd0));
        // Packet lock: requester 2 (5 beats) wins after last_id=0, 0 waits.
        vecs.push_back(mk(4'b0101, 4'b0000, 0, 4'd0, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(4'b0101, 4'b0000, 0, 4'd1, 1, 4'b0100, 1, 2'd2));
        vecs.push_back(mk(4'b0101, 4'b0000, 0, 4'd2, 1, 4'b0100, 1, 2'd2));
        vecs.push_back(mk(4'b0101, 4'b0000, 0, 4'd3, 1, 4'b0100, 1, 2'd2));
        vecs.push_back(mk(4'b0101, 4'b0000, 0, 4'd4, 1, 4'b0100, 1, 2'd2));
        vecs.push_back(mk(4'b0101, 4'b0100, 0, 4'd5, 1, 4'b0100, 1, 2'd2));
        vecs.push_back(mk(4'b0001, 4'b0001, 0, 4'd0, 0, 4'b0000, 0, 2'd2));
        vecs.push_back(mk(4'b0001, 4'b0001, 0, 4'd6, 1, 4'b0001, 1, 2'd0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'd0, 0, 4'b0000, 0, 2'd0));
        // Full stall mid-packet for requester 1.
        vecs.push_back(mk(4'b0010, 4'b0000, 0, 4'd0, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(4'b0010, 4'b0000, 0, 4'd1, 1, 4'b0010, 1, 2'd1));
        vecs.push_back(mk(4'b0010, 4'b0000, 0, 4'd2, 1, 4'b0010, 1, 2'd1));
        vecs.push_back(mk(4'b0010, 4'b0000, 1, 4'd3, 0, 4'b0000, 1, 2'd1));
        vecs.push_back(mk(4'b0010, 4'b0000, 1, 4'd3, 0, 4'b0000, 1, 2'd1));
        vecs.push_back(mk(4'b0010, 4'b0000, 1, 4'd3, 0, 4'b0000, 1, 2'd1));
        vecs.push_back(mk(4'b0010, 4'b0000, 0, 4'd3, 1, 4'b0010, 1, 2'd1));
        vecs.push_back(mk(4'b0010, 4'b0010, 0, 4'd4, 1, 4'b0010, 1, 2'd1));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'd0, 0, 4'b0000, 0, 2'd1));

        do_reset();
        foreach (vecs[k]) begin
            drive(vecs[k].v, vecs[k].l, vecs[k].f, vecs[k].d);
            chk_a($sformatf("vec%0d", k), vecs[k].e_winc, vecs[k].e_ready,
                  vecs[k].e_busy, vecs[k].e_gid, vecs[k].d);
            adv();
        end

        // Beat cap (MAXBEATS=4) with a 2-cycle stall inside: the count must hold.
        do_reset();
        drive(4'b0010, 4'b0000, 0, 4'd0); chk_b("cap.c0", 0, 4'b0000, 0, 0, 2'd0, 4'd0); adv();
        drive(4'b0010, 4'b0000, 0, 4'd1); chk_b("cap.c1", 1, 4'b0010, 0, 1, 2'd1, 4'd1); adv();
        drive(4'b0010, 4'b0000, 0, 4'd2); chk_b("cap.c2", 1, 4'b0010, 0, 1, 2'd1, 4'd2); adv();
        drive(4'b0010, 4'b0000, 1, 4'd3); chk_b("cap.s1", 0, 4'b0000, 0, 1, 2'd1, 4'd3); adv();
        drive(4'b0010, 4'b0000, 1, 4'd3); chk_b("cap.s2", 0, 4'b0000, 0, 1, 2'd1, 4'd3); adv();
        drive(4'b0010, 4'b0000, 0, 4'd3); chk_b("cap.c3", 1, 4'b0010, 0, 1, 2'd1, 4'd3); adv();
        drive(4'b0010, 4'b0000, 0, 4'd4); chk_b("cap.c4", 1, 4'b0010, 0, 1, 2'd1, 4'd4); adv();
        drive(4'b0010, 4'b0000, 0, 4'd5); chk_b("cap.rel", 0, 4'b0000, 1, 0, 2'd1, 4'd5); adv();
        drive(4'b0010, 4'b0000, 0, 4'd5); chk_b("cap.c5", 1, 4'b0010, 0, 1, 2'd1, 4'd5); adv();
        drive(4'b0010, 4'b0010, 0, 4'd6); chk_b("cap.c6", 1, 4'b0010, 0, 1, 2'd1, 4'd6); adv();
        drive(4'b0000, 4'b0000, 0, 4'd0); chk_b("cap.end", 0, 4'b0000, 0, 0, 2'd1, 4'd0); adv();

        // Cap coinciding with last: normal release, no cap_err.
        drive(4'b0010, 4'b0000, 0, 4'd0); chk_b("cwl.c0", 0, 4'b0000, 0, 0, 2'd1, 4'd0); adv();
        drive(4'b0010, 4'b0000, 0, 4'd1); chk_b("cwl.c1", 1, 4'b0010, 0, 1, 2'd1, 4'd1); adv();
        drive(4'b0010, 4'b0000, 0, 4'd2); chk_b("cwl.c2", 1, 4'b0010, 0, 1, 2'd1, 4'd2); adv();
        drive(4'b0010, 4'b0000, 0, 4'd3); chk_b("cwl.c3", 1, 4'b0010, 0, 1, 2'd1, 4'd3); adv();
        drive(4'b0010, 4'b0010, 0, 4'd4); chk_b("cwl.c4", 1, 4'b0010, 0, 1, 2'd1, 4'd4); adv();
        drive(4'b0000, 4'b0000, 0, 4'd0); chk_b("cwl.rel", 0, 4'b0000, 0, 0, 2'd1, 4'd0); adv();
        drive(4'b0000, 4'b0000, 0, 4'd0); chk_b("cwl.idle", 0, 4'b0000, 0, 0, 2'd1, 4'd0); adv();

        // Reset during beat 2 of a packet from requester 2.
        do_reset();
        drive(4'b0100, 4'b0000, 0, 4'd0); chk_a("mrst.c0", 0, 4'b0000, 0, 2'd0, 4'd0); adv();
        drive(4'b0100, 4'b0000, 0, 4'd1); chk_a("mrst.b1", 1, 4'b0100, 1, 2'd2, 4'd1); adv();
        req_valid = 4'b0100;
        dnib      = 4'd2;
        #1;
        check("mrst.b2_winc", 32'(winc_a), 1);
        #2;
        wrst_n = 1'b0;
        #1;
        check("mrst.winc", 32'(winc_a), 0);
        check("mrst.ready", 32'(ready_a), 0);
        check("mrst.busy", 32'(busy_a), 0);
        check("mrst.gid", 32'(gid_a), 0);
        check("mrst.cap", 32'(cap_a), 0);
        @(posedge wclk);
        @(negedge wclk);
        req_valid = 4'b0101;
        req_last  = 4'b0101;
        dnib      = 4'd7;
        wrst_n    = 1'b1;
        #1;
        chk_a("mrst.idle", 0, 4'b0000, 0, 2'd0, 4'd7);
        adv();
        drive(4'b0101, 4'b0101, 0, 4'd7); chk_a("mrst.r0", 1, 4'b0001, 1, 2'd0, 4'd7); adv();
        drive(4'b0000, 4'b0000, 0, 4'd0); chk_a("mrst.end", 0, 4'b0000, 0, 2'd0, 4'd0); adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
